// File: rtl/sram_burst_initiator.sv
// Burst initiator for a single-port synchronous SRAM: accepts address/length
// commands, streams write beats to registered strobes and returns read beats.
module sram_burst_initiator #(
  parameter int BW_DATA = 64,
  parameter int BW_ADDR = 6,
  parameter int RD_LAT  = 1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_wr,
  input  logic [BW_ADDR-1:0] i_cmd_addr,
  input  logic [BW_ADDR-1:0] i_cmd_len,
  input  logic               i_wdata_valid,
  output logic               o_wdata_ready,
  input  logic [BW_DATA-1:0] i_wdata,
  output logic               o_rdata_valid,
  output logic [BW_DATA-1:0] o_rdata,
  output logic               o_busy,
  output logic               o_sram_cen,
  output logic               o_sram_wen,
  output logic               o_sram_oen,
  output logic [BW_ADDR-1:0] o_sram_addr,
  output logic [BW_DATA-1:0] o_sram_data,
  input  logic [BW_DATA-1:0] i_sram_data
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BW_ADDR-1:0]   r_addr;
  logic [BW_ADDR-1:0]   r_cnt;
  logic                 r_cen_p0;
  logic                 r_wen_p0;
  logic                 r_oen_p0;
  logic [BW_ADDR-1:0]   r_sram_addr_p0;
  logic [BW_DATA-1:0]   r_sram_data_p0;
  logic [RD_LAT-1:0]    r_rd_vld_p1;
  logic                 r_rdata_vld_p2;
  logic [BW_DATA-1:0]   r_rdata_p2;
  logic                 w_cmd_acc;
  logic                 w_wr_acc;
  logic                 w_rd_issue;
  logic                 w_last;
  logic                 w_pipe_empty;

  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_acc    = 1'b0;
    w_wr_acc     = 1'b0;
    w_rd_issue   = 1'b0;
    w_last       = (r_cnt == '0);
    // The strobe cycle itself counts as in flight until its tracker bit is set.
    w_pipe_empty = !r_oen_p0 && (r_rd_vld_p1 == '0);
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_cmd_acc   = 1'b1;
          w_state_nxt = i_cmd_wr ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (i_wdata_valid) begin
          w_wr_acc = 1'b1;
          if (w_last) w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        w_rd_issue = 1'b1;
        if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pipe_empty) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Stage p0: command/beat bookkeeping and registered SRAM strobes
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_addr         <= '0;
      r_cnt          <= '0;
      r_cen_p0       <= 1'b0;
      r_wen_p0       <= 1'b0;
      r_oen_p0       <= 1'b0;
      r_sram_addr_p0 <= '0;
      r_sram_data_p0 <= '0;
    end else begin
      if (w_cmd_acc) begin
        r_addr <= i_cmd_addr;
        r_cnt  <= i_cmd_len;
      end else if (w_wr_acc || w_rd_issue) begin
        r_addr <= r_addr + BW_ADDR'(1);
        r_cnt  <= r_cnt - BW_ADDR'(1);
      end
      r_cen_p0 <= w_wr_acc || w_rd_issue;
      r_wen_p0 <= w_wr_acc;
      r_oen_p0 <= w_rd_issue;
      if (w_wr_acc || w_rd_issue) r_sram_addr_p0 <= r_addr;
      if (w_wr_acc)               r_sram_data_p0 <= i_wdata;
    end
  end

  // Stage p1/p2: track read strobes for RD_LAT cycles, then register the SRAM word
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rd_vld_p1    <= '0;
      r_rdata_vld_p2 <= 1'b0;
      r_rdata_p2     <= '0;
    end else begin
      r_rd_vld_p1    <= (r_rd_vld_p1 << 1) | RD_LAT'(r_oen_p0);
      r_rdata_vld_p2 <= r_rd_vld_p1[RD_LAT-1];
      if (r_rd_vld_p1[RD_LAT-1]) r_rdata_p2 <= i_sram_data;
    end
  end

  assign o_cmd_ready   = (r_state == S_IDLE);
  assign o_wdata_ready = (r_state == S_WRITE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_sram_cen    = r_cen_p0;
  assign o_sram_wen    = r_wen_p0;
  assign o_sram_oen    = r_oen_p0;
  assign o_sram_addr   = r_sram_addr_p0;
  assign o_sram_data   = r_sram_data_p0;
  assign o_rdata_valid = r_rdata_vld_p2;
  assign o_rdata       = r_rdata_p2;

endmodule

// File: tb/tb_sram_burst_initiator.sv
// Scoreboard bench for sram_burst_initiator with a behavioural SRAM array and
// a burst-level reference model that predicts strobes and returned data.
module tb_sram_burst_initiator;
  localparam int BD  = 64;
  localparam int BA  = 6;
  localparam int LAT = 2;

  typedef struct {
    logic [BA-1:0] a;
    logic          wr;
    logic [BD-1:0] d;
  } st_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [BA-1:0] cmd_addr = '0, cmd_len = '0;
  logic          wvalid = 1'b0;
  logic [BD-1:0] wdata = '0;
  logic          o_cmd_ready, o_wdata_ready, o_rdata_valid, o_busy;
  logic          o_sram_cen, o_sram_wen, o_sram_oen;
  logic [BD-1:0] o_rdata, o_sram_data, i_sram_data;
  logic [BA-1:0] o_sram_addr;

  sram_burst_initiator #(.BW_DATA(BD), .BW_ADDR(BA), .RD_LAT(LAT)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(cmd_wr),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wdata_valid(wvalid), .o_wdata_ready(o_wdata_ready), .i_wdata(wdata),
    .o_rdata_valid(o_rdata_valid), .o_rdata(o_rdata), .o_busy(o_busy),
    .o_sram_cen(o_sram_cen), .o_sram_wen(o_sram_wen), .o_sram_oen(o_sram_oen),
    .o_sram_addr(o_sram_addr), .o_sram_data(o_sram_data), .i_sram_data(i_sram_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_rd_cycle = -100, last_wst_cycle = -100;
  bit cur_wr = 1'b0, prev_busy = 1'b0, chk_drained = 1'b0, init_mem = 1'b1;

  st_t           exp_st[$];
  logic [BD-1:0] exp_rd[$];
  int            acc_q[$];
  int            rdst_q[$];
  logic [BD-1:0] beats[$];
  logic [BD-1:0] ref_mem [2**BA];
  logic [BD-1:0] sram_mem [2**BA];
  logic [BD-1:0] sram_pipe [LAT];
  st_t           mon_e;

  function automatic logic [BD-1:0] init_word(input int i);
    return 64'(i) * 64'h0101_0101_0101_0101 ^ 64'hC3A5_5A3C_0F0F_F0F0;
  endfunction

  function automatic void check(input string nm, input logic [BD-1:0] act,
                                input logic [BD-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // External SRAM array: word visible on i_sram_data LAT cycles after the strobe cycle.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 2**BA; i++) sram_mem[i] <= init_word(i);
    end else if (o_sram_cen && o_sram_wen) begin
      sram_mem[o_sram_addr] <= o_sram_data;
    end
    sram_pipe[0] <= (o_sram_cen && o_sram_oen) ? sram_mem[o_sram_addr]
                                               : {$urandom, $urandom};
    for (int i = 1; i < LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
  end
  assign i_sram_data = sram_pipe[LAT-1];

  // Monitor: pops predictions whenever the DUT strobes the SRAM or returns data.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_busy = 1'b0;
    end else begin
      check("ready_vs_busy", 64'(o_cmd_ready), 64'(!o_busy));
      if (wvalid && o_wdata_ready) acc_q.push_back(cyc);
      if (o_sram_cen) begin
        strobe_cnt++;
        if (exp_st.size() == 0) begin
          check("unexpected_strobe", 64'(o_sram_addr), 64'hFFFF);
        end else begin
          mon_e = exp_st.pop_front();
          check("strobe_kind_addr", {55'd0, o_sram_wen, o_sram_oen, o_sram_addr},
                {55'd0, mon_e.wr, !mon_e.wr, mon_e.a});
          if (mon_e.wr) check("strobe_wdata", o_sram_data, mon_e.d);
        end
        if (o_sram_wen) begin
          last_wst_cycle = cyc;
          if (acc_q.size() == 0) check("wstrobe_without_beat", 64'(cyc), 64'hFFFF);
          else check("wstrobe_delay", 64'(cyc - acc_q.pop_front()), 64'd1);
        end else begin
          rdst_q.push_back(cyc);
        end
      end
      if (o_rdata_valid) begin
        last_rd_cycle = cyc;
        if (exp_rd.size() == 0) check("unexpected_rdata", o_rdata, 64'hDEAD);
        else check("rdata", o_rdata, exp_rd.pop_front());
        if (rdst_q.size() == 0) check("rdata_without_strobe", 64'(cyc), 64'hFFFF);
        else check("rdata_latency", 64'(cyc - rdst_q.pop_front()), 64'(LAT + 1));
      end
      if (prev_busy && !o_busy) begin
        if (cur_wr) check("busy_fall_write", 64'(last_wst_cycle), 64'(cyc));
        else        check("busy_fall_read", 64'(last_rd_cycle), 64'(cyc - 1));
      end
      prev_busy = o_busy;
    end
  end

  // Call #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input bit wr, input logic [BA-1:0] a, input logic [BA-1:0] len);
    int w = 0;
    logic [BA-1:0] ad;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = len;
    @(negedge clk);
    while (!o_cmd_ready && w < 400) begin w++; @(negedge clk); end
    if (!o_cmd_ready) check("cmd_ready_timeout", 64'(o_cmd_ready), 64'd1);
    if (chk_drained) begin
      #1 check("prior_burst_drained", 64'(exp_rd.size()), 64'd0);
      check("waited_while_busy", 64'(w > 0), 64'd1);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cur_wr = wr;
    for (int i = 0; i <= int'(len); i++) begin
      ad = BA'(int'(a) + i);
      if (wr) begin
        ref_mem[ad] = beats[i];
        exp_st.push_back('{a: ad, wr: 1'b1, d: beats[i]});
      end else begin
        exp_st.push_back('{a: ad, wr: 1'b0, d: '0});
        exp_rd.push_back(ref_mem[ad]);
      end
    end
  endtask

  // mode 0: back-to-back, 1: random gaps, 2: fixed 1,0,0,1,0,1 pattern
  task automatic drive_beats(input int n, input int mode);
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int k = 0, t = 0;
    bit v;
    while (k < n && t < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 2) != 0);
        default: v = (t < 6) ? pat[t] : 1'b1;
      endcase
      wvalid = v;
      wdata  = v ? beats[k] : {$urandom, $urandom};
      @(negedge clk);
      if (v && o_wdata_ready) k++;
      @(posedge clk); #1;
      t++;
    end
    if (k < n) check("wbeat_timeout", 64'(k), 64'(n));
    wvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while ((o_busy || exp_st.size() != 0 || exp_rd.size() != 0) && w < 500) begin
      w++; @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("burst_complete", 64'(exp_st.size() + exp_rd.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic fill_beats(input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom});
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_strobes"}, {61'd0, o_sram_cen, o_sram_wen, o_sram_oen}, 64'd0);
    check({nm, "_rvalid_busy_wrdy"}, {61'd0, o_rdata_valid, o_busy, o_wdata_ready}, 64'd0);
    check({nm, "_cmd_ready"}, 64'(o_cmd_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int base, w;
    for (int i = 0; i < 2**BA; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_addr_data", {o_sram_addr, o_sram_data ^ o_rdata}, '0);
    @(posedge clk); #1;
    rstn = 1'b1; init_mem = 1'b0;
    @(posedge clk); #1;

    // single write then read
    beats.delete(); beats.push_back(64'hDEADBEEF_01234567);
    issue(1'b1, 6'h05, 6'd0); drive_beats(1, 0); wait_idle();
    issue(1'b0, 6'h05, 6'd0); wait_idle();

    // bank-crossing burst
    beats.delete(); for (int i = 1; i <= 4; i++) beats.push_back(64'(i));
    issue(1'b1, 6'h0E, 6'd3); drive_beats(4, 0); wait_idle();
    issue(1'b0, 6'h0E, 6'd3); wait_idle();

    // wrap-around read
    issue(1'b0, 6'h3E, 6'd3); wait_idle();

    // write stalls
    fill_beats(3);
    issue(1'b1, 6'h21, 6'd2); drive_beats(3, 2); wait_idle();
    issue(1'b0, 6'h21, 6'd2); wait_idle();

    // command held while busy
    issue(1'b0, 6'h10, 6'd7);
    chk_drained = 1'b1;
    issue(1'b0, 6'h30, 6'd1);
    chk_drained = 1'b0;
    wait_idle();

    // asynchronous reset mid-read-burst
    base = strobe_cnt; w = 0;
    issue(1'b0, 6'h20, 6'd7);
    while (strobe_cnt < base + 2 && w < 50) begin @(negedge clk); #1; w++; end
    check("pre_reset_strobes", 64'(strobe_cnt - base), 64'd2);
    #1 rstn = 1'b0;
    #1 check_idle_outputs("abort");
    exp_st.delete(); exp_rd.delete(); acc_q.delete(); rdst_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (12) @(negedge clk);
    check_idle_outputs("after_abort");
    @(posedge clk); #1;

    // randomized bursts, including a full-length one
    for (int it = 0; it < 24; it++) begin
      bit wr;
      logic [BA-1:0] a, len;
      wr  = $urandom_range(0, 1);
      a   = BA'($urandom);
      len = (it == 5 || it == 6) ? 6'h3F : BA'($urandom_range(0, 9));
      if (it == 5) wr = 1'b1;
      if (it == 6) wr = 1'b0;
      if (wr) begin
        fill_beats(int'(len) + 1);
        issue(1'b1, a, len);
        drive_beats(int'(len) + 1, 1);
      end else begin
        issue(1'b0, a, len);
      end
      if ($urandom_range(0, 1) == 1 || it == 23) wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
